// File: rtl/pluto_spi_frame_if.sv
// Pin and system-side bundle for the Pluto SPI frame engine.
// The master modport is the SPI host plus fabric side; the slave modport is the frame engine.
interface pluto_spi_frame_if #(
  parameter int NCH = 4,
  parameter int DW  = 10
);
  logic              SCK;
  logic              SSEL;
  logic              MOSI;
  logic              MISO;
  logic [32*NCH-1:0] rd_data;
  logic [16*NCH-1:0] wr_data;
  logic [DW-1:0]     dout;
  logic              commit;
  logic              frame_err;
  logic              wdt_expired;

  modport master (
    output SCK, SSEL, MOSI, rd_data,
    input  MISO, wr_data, dout, commit, frame_err, wdt_expired
  );

  modport slave (
    input  SCK, SSEL, MOSI, rd_data,
    output MISO, wr_data, dout, commit, frame_err, wdt_expired
  );
endinterface

// File: rtl/pluto_spi_frame.sv
// SPI mode-0 slave frame engine: snapshot readback at frame start, atomic command commit at frame end,
// watchdog forcing safe-zero outputs. Optional trailing checksum byte enabled by PLUTO_SPI_CHKSUM_EN.
module pluto_spi_frame #(
  parameter int NCH     = 4,
  parameter int DW      = 10,
  parameter int WDT_CYC = 400000
) (
  input logic            clk,
  input logic            rst,
  pluto_spi_frame_if.slave bus
);

  localparam int DB    = (DW + 7) / 8;
`ifdef PLUTO_SPI_CHKSUM_EN
  localparam int NB    = 2*NCH + DB + 1;
`else
  localparam int NB    = 2*NCH + DB;
`endif
  localparam int NSNAP = 4*NCH;
  localparam int WDT_W = $clog2(WDT_CYC + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYC - 1);
  localparam logic [5:0] NB_C    = 6'(NB);
  localparam logic [5:0] NSNAP_C = 6'(NSNAP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CLOSE = 2'd2
  } state_t;

  // XOR of every readback byte in a snapshot
  function automatic logic [7:0] snap_xor(input logic [32*NCH-1:0] v);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < NSNAP; i++) begin
      acc = acc ^ v[8*i +: 8];
    end
    return acc;
  endfunction

  logic [2:0]        sck_sync_r;
  logic [2:0]        ssel_sync_r;
  logic [1:0]        mosi_sync_r;
  state_t            state_r;
  logic              start_pend_r;
  logic [32*NCH-1:0] snap_r;
  logic [7:0]        shadow_r [NB];
  logic [7:0]        rx_r;
  logic [7:0]        tx_r;
  logic [2:0]        bitcnt_r;
  logic [5:0]        bytecnt_r;
  logic              err_sticky_r;
  logic              wdt_expired_r;
  logic              commit_r;
  logic              frame_err_r;
  logic [16*NCH-1:0] wr_data_r;
  logic [DW-1:0]     dout_r;
  logic [WDT_W-1:0]  wdt_cnt_r;

  logic              sck_rise_s;
  logic              sck_fall_s;
  logic              start_s;
  logic              end_s;
  logic [7:0]        rx_next_s;
  logic [7:0]        status_s;
  logic [7:0]        tx_byte_s;
  logic              frame_ok_s;
  logic [16*NCH-1:0] wr_next_s;
  logic [DW-1:0]     dout_next_s;
`ifdef PLUTO_SPI_CHKSUM_EN
  logic [7:0]        payload_xor_s;
`endif

  // Pin synchronisers; SCK and SSEL get an extra stage so edges are judged on settled flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_r  <= 3'b000;
      ssel_sync_r <= 3'b000;
      mosi_sync_r <= 2'b00;
    end else begin
      sck_sync_r  <= {sck_sync_r[1:0], bus.SCK};
      ssel_sync_r <= {ssel_sync_r[1:0], bus.SSEL};
      mosi_sync_r <= {mosi_sync_r[0], bus.MOSI};
    end
  end

  // Edge events and byte assembly
  always_comb begin
    sck_rise_s = sck_sync_r[1] & ~sck_sync_r[2];
    sck_fall_s = ~sck_sync_r[1] & sck_sync_r[2];
    start_s    = ~ssel_sync_r[1] & ssel_sync_r[2];
    end_s      = ssel_sync_r[1] & ~ssel_sync_r[2];
    rx_next_s  = {rx_r[6:0], mosi_sync_r[1]};
    status_s   = {6'b000000, wdt_expired_r, err_sticky_r};
  end

  // Next MISO byte selected by the byte counter
  always_comb begin
    tx_byte_s = 8'h00;
    if (bytecnt_r < NSNAP_C) begin
      tx_byte_s = snap_r[{bytecnt_r, 3'b000} +: 8];
    end else if (bytecnt_r == NSNAP_C) begin
      tx_byte_s = status_s;
`ifdef PLUTO_SPI_CHKSUM_EN
    end else if (bytecnt_r == NSNAP_C + 6'd1) begin
      tx_byte_s = snap_xor(snap_r) ^ status_s;
`endif
    end else begin
      tx_byte_s = 8'h00;
    end
  end

  // Frame acceptance and the values a commit would publish
  always_comb begin
    frame_ok_s  = (bytecnt_r == NB_C) && (bitcnt_r == 3'd0);
`ifdef PLUTO_SPI_CHKSUM_EN
    payload_xor_s = 8'h00;
    for (int i = 0; i < NB - 1; i++) begin
      payload_xor_s = payload_xor_s ^ shadow_r[i];
    end
    frame_ok_s = frame_ok_s && (payload_xor_s == shadow_r[NB-1]);
`endif
    wr_next_s = {(16*NCH){1'b0}};
    for (int k = 0; k < NCH; k++) begin
      wr_next_s[16*k +: 16] = {shadow_r[2*k+1], shadow_r[2*k]};
    end
    dout_next_s = {DW{1'b0}};
    for (int i = 0; i < DW; i++) begin
      dout_next_s[i] = shadow_r[2*NCH + i/8][i%8];
    end
  end

  // Frame FSM, shift registers, commit/reject and watchdog; a commit overrides a same-cycle expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      start_pend_r  <= 1'b0;
      snap_r        <= {(32*NCH){1'b0}};
      for (int i = 0; i < NB; i++) begin
        shadow_r[i] <= 8'h00;
      end
      rx_r          <= 8'h00;
      tx_r          <= 8'h00;
      bitcnt_r      <= 3'd0;
      bytecnt_r     <= 6'd0;
      err_sticky_r  <= 1'b0;
      wdt_expired_r <= 1'b0;
      commit_r      <= 1'b0;
      frame_err_r   <= 1'b0;
      wr_data_r     <= {(16*NCH){1'b0}};
      dout_r        <= {DW{1'b0}};
      wdt_cnt_r     <= {WDT_W{1'b0}};
    end else begin
      commit_r    <= 1'b0;
      frame_err_r <= 1'b0;

      if (wdt_cnt_r == WDT_LAST) begin
        wdt_expired_r <= 1'b1;
        wr_data_r     <= {(16*NCH){1'b0}};
        dout_r        <= {DW{1'b0}};
      end else begin
        wdt_cnt_r <= wdt_cnt_r + {{(WDT_W-1){1'b0}}, 1'b1};
      end

      case (state_r)
        ST_IDLE: begin
          if (start_s || start_pend_r) begin
            snap_r       <= bus.rd_data;
            tx_r         <= bus.rd_data[7:0];
            bitcnt_r     <= 3'd0;
            bytecnt_r    <= 6'd0;
            start_pend_r <= 1'b0;
            state_r      <= ST_SHIFT;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          if (end_s) begin
            state_r <= ST_CLOSE;
          end else if (sck_rise_s) begin
            rx_r     <= rx_next_s;
            bitcnt_r <= bitcnt_r + 3'd1;
            if (bitcnt_r == 3'd7) begin
              // Surplus bytes advance the counter but never land in the shadow
              for (int i = 0; i < NB; i++) begin
                if (bytecnt_r == 6'(i)) begin
                  shadow_r[i] <= rx_next_s;
                end
              end
              if (bytecnt_r != 6'd63) begin
                bytecnt_r <= bytecnt_r + 6'd1;
              end
            end
          end else if (sck_fall_s) begin
            if ((bitcnt_r == 3'd0) && (bytecnt_r != 6'd0)) begin
              tx_r <= tx_byte_s;
            end else begin
              tx_r <= {tx_r[6:0], 1'b0};
            end
          end else begin
            state_r <= ST_SHIFT;
          end
        end

        ST_CLOSE: begin
          start_pend_r <= start_s;
          state_r      <= ST_IDLE;
          if (frame_ok_s) begin
            wr_data_r     <= wr_next_s;
            dout_r        <= dout_next_s;
            commit_r      <= 1'b1;
            wdt_cnt_r     <= {WDT_W{1'b0}};
            wdt_expired_r <= 1'b0;
            err_sticky_r  <= 1'b0;
          end else begin
            frame_err_r  <= 1'b1;
            err_sticky_r <= 1'b1;
          end
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.MISO        = tx_r[7];
  assign bus.wr_data     = wr_data_r;
  assign bus.dout        = dout_r;
  assign bus.commit      = commit_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.wdt_expired = wdt_expired_r;

endmodule

// File: doc/pluto_spi_frame.md
Name: pluto_spi_frame

Overview:
- Parametrised SPI slave frame engine for the Pluto servo firmware. Supports NCH channels and a DW-bit digital-output register.
- Each frame moves NCH 32-bit readback words out on MISO and takes NCH 16-bit command words plus DW output bits in on MOSI.
- Adds three things the fixed 4-channel slave did not have:
  - readback snapshot taken atomically at frame start;
  - write commit applied atomically at frame end, and only for well-formed frames;
  - watchdog that forces all commands to safe zero.
- Sits between the SPI pins and the PWM/quadrature/IO blocks.

Parameters:
NCH, 4, number of channels (1..8)
DW, 10, digital-output bits (1..16); DB = ceil(DW/8) MOSI bytes
WDT_CYC, 400000, clk cycles without a committed frame before watchdog trips (10 ms @ 40 MHz)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
SCK  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
SSEL  in  1  SPI select, active low, asynchronous
MOSI  in  1  SPI data in, MSB first
MISO  out  1  SPI data out, MSB first
rd_data  in  32*NCH  readback words; channel k at [32k+31:32k]
wr_data  out  16*NCH  committed command words; channel k at [16k+15:16k]
dout  out  DW  committed digital-output register
commit  out  1  one-clk pulse when a frame is committed
frame_err  out  1  one-clk pulse when a frame is rejected
wdt_expired  out  1  high while the watchdog is tripped

Behaviour:
- Reset: wr_data=0, dout=0, commit=0, frame_err=0, wdt_expired=0, MISO=0, all counters and shadow registers =0.
- Synchronisers: SCK and SSEL pass through 3-flop chains, MOSI through a 2-flop chain. Edges are detected on the top two flops: SSEL 1->0 = start, 0->1 = end.
- States: IDLE, SHIFT, CLOSE.
  - IDLE -> SHIFT on start.
  - SHIFT -> CLOSE on end.
  - CLOSE -> IDLE after exactly 1 clk.
  - Start while in CLOSE is handled on the next cycle.
- On start:
  - rd_data is latched into a snapshot register;
  - bitcnt=0, bytecnt=0;
  - MISO shift register is loaded with snapshot byte 0.
- Receive:
  - each SCK rising edge in SHIFT shifts MOSI into rx[7:0] and increments bitcnt (3-bit, wraps);
  - on wrap 7->0: rx byte is stored to shadow[bytecnt], bytecnt increments, saturating at 63.
  - Bytes beyond the expected count are counted but discarded.
- MOSI byte map (per 16-bit word, low byte first):
  - bytes 2k, 2k+1 = wr_data[k];
  - then DB bytes of dout, low byte first; bits above DW are ignored.
  - Expected count NB = 2*NCH + DB.
- Transmit:
  - on each SCK falling edge, if the byte just completed (bitcnt==0 and bytecnt>0), load tx byte bytecnt; otherwise shift left with 0 fill.
  - MISO = tx[7].
  - tx byte j: j<4*NCH gives snapshot word j/4, byte j%4, little-endian; j==4*NCH gives status {6'b0, wdt_expired, err_sticky}; j>4*NCH gives 8'h00.
- On end (CLOSE cycle):
  - If bytecnt==NB and bitcnt==0: shadow -> wr_data/dout in one clk, commit=1, watchdog counter cleared, wdt_expired cleared, err_sticky cleared.
  - Otherwise: outputs unchanged, frame_err=1, err_sticky=1.
  - commit and frame_err are never high in the same cycle.
  - Latency: commit asserts 1 clk after the synchronised SSEL edge, i.e. 3–4 clk after the pin edge.
- Watchdog:
  - counter increments every clk and saturates;
  - when it reaches WDT_CYC-1: wdt_expired=1 and wr_data=0, dout=0 on the next clk;
  - it stays tripped until a committed frame.
  - If a commit and expiry occur in the same cycle, the commit wins.
- SSEL rising mid-byte counts as a malformed frame (bitcnt!=0) and is rejected.
- rst asserted mid-frame clears everything immediately. With SSEL still low after rst, the engine waits for a fresh start edge before shifting.

Optional Feature:
- Macro: PLUTO_SPI_CHKSUM_EN.
- Defined:
  - NB becomes 2*NCH+DB+1; the final MOSI byte must equal the XOR of all prior payload bytes, else the frame is rejected (frame_err=1, no commit);
  - the MISO byte after the status byte is the XOR of the 4*NCH snapshot bytes plus the status byte.
- Undefined: no checksum byte, and MISO after the status byte is 8'h00.

Test Plan:
- Frame with NCH=2, DW=10, MOSI 34 12 78 56 FF 03 -> commit pulse; wr_data=32'h56781234, dout=10'h3FF; MISO returns rd_data bytes little-endian from the start-time snapshot even though rd_data changes mid-frame.
- 5-byte frame (34 12 78 56 FF) -> frame_err pulse; wr_data/dout keep their previous values; the next frame's status byte = 8'h01.
- SSEL raised after 3 bits of byte 4 -> rejected; no commit.
- No frames for WDT_CYC clks after a commit of 1234/5678 -> wdt_expired=1, wr_data=0, dout=0; a following good frame clears wdt_expired; status byte 8'h02 before it.
- rst asserted mid-frame while SSEL low -> all outputs 0; further SCK edges ignored until a new SSEL falling edge.
- With PLUTO_SPI_CHKSUM_EN: 34 12 78 56 FF 03 F4 -> commit; same frame with F5 as the last byte -> frame_err, no commit.
